pulse_emitter: RTL and testbench

PULSE_EMITTER -- requirements
Module: pulse_emitter

---
 rtl/pulse_emitter.sv | 142 ++++++++++++++
 tb/tb_pulse_emitter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pulse_emitter.sv
// Delayed pulse generator: an accepted trigger at edge k drives pulse_out high after edges k+DELAY..k+DELAY+PULSE_WIDTH-1.
// No backpressure: triggers inside the dead time are ignored, and triggers that arrive when the queue is full are dropped and set overflow.
module pulse_emitter #(
    parameter int DELAY       = 50,
    parameter int PULSE_WIDTH = 4,
    parameter int DEPTH       = 4,
    parameter int TS_WIDTH    = $clog2(DELAY + PULSE_WIDTH + 1) + 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trig_in,
    input  logic       enable,
    output logic       pulse_out,
    output logic       busy,
    output logic       queue_full,
    output logic       queue_empty,
    output logic       overflow,
    output logic [7:0] pulse_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int DT_W  = $clog2(PULSE_WIDTH + 2);
    localparam int PWC_W = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EMIT} state_t;

    state_t              r_state;
    logic [TS_WIDTH-1:0] r_ts;
    logic [TS_WIDTH-1:0] r_fifo [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [DT_W-1:0]     r_since;
    logic [PWC_W-1:0]    r_width_cnt;
    logic                r_pulse;
    logic                r_overflow;
    logic [7:0]          r_pulse_count;

    logic [TS_WIDTH-1:0] w_ts_next;
    logic [TS_WIDTH-1:0] w_age;
    logic                w_full;
    logic                w_dead_ok;
    logic                w_pop;
    logic                w_cand;
    logic                w_push;
    logic                w_drop;
    logic [CNT_W-1:0]    w_count_next;

    function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Timestamps are stamped with the post-edge value so that age == DELAY-1 lands on edge k+DELAY.
    assign w_ts_next = r_ts + TS_WIDTH'(1);
    assign w_age     = r_ts - r_fifo[r_rd_ptr];
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_dead_ok = (r_since >= DT_W'(PULSE_WIDTH + 1));
    assign w_pop     = (r_state == S_EMIT) && (r_width_cnt == PWC_W'(PULSE_WIDTH - 1));
    assign w_cand    = trig_in && enable && w_dead_ok;
    assign w_push    = w_cand && (!w_full || w_pop);
    assign w_drop    = w_cand && w_full && !w_pop;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop)
            w_count_next = r_count + CNT_W'(1);
        else if (!w_push && w_pop)
            w_count_next = r_count - CNT_W'(1);
    end

    // Saturating elapsed-cycle counter avoids false dead-time hits after the timestamp wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ts       <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_since    <= DT_W'(PULSE_WIDTH + 1);
            r_overflow <= 1'b0;
        end else begin
            r_ts    <= w_ts_next;
            r_count <= w_count_next;
            if (w_push) begin
                r_wr_ptr <= f_next(r_wr_ptr);
                r_since  <= DT_W'(1);
            end else if (!w_dead_ok) begin
                r_since <= r_since + DT_W'(1);
            end
            if (w_pop)
                r_rd_ptr <= f_next(r_rd_ptr);
            if (w_drop)
                r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_fifo[r_wr_ptr] <= w_ts_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_pulse       <= 1'b0;
            r_width_cnt   <= '0;
            r_pulse_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_count != '0)
                        r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_age == TS_WIDTH'(DELAY - 1)) begin
                        r_state     <= S_EMIT;
                        r_pulse     <= 1'b1;
                        r_width_cnt <= '0;
                    end
                end
                S_EMIT: begin
                    if (w_pop) begin
                        r_pulse       <= 1'b0;
                        r_pulse_count <= r_pulse_count + 8'd1;
                        r_state       <= (w_count_next != '0) ? S_WAIT : S_IDLE;
                    end else begin
                        r_width_cnt <= r_width_cnt + PWC_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign pulse_out   = r_pulse;
    assign busy        = (r_state != S_IDLE);
    assign queue_full  = w_full;
    assign queue_empty = (r_count == '0);
    assign overflow    = r_overflow;
    assign pulse_count = r_pulse_count;

endmodule

// File: tb/tb_pulse_emitter.sv
// Bench for pulse_emitter: directed scenarios plus random triggers, checked every cycle against a queue-based model.
module tb_pulse_emitter;

    localparam int D  = 50;
    localparam int PW = 4;
    localparam int DP = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       trig_in;
    logic       enable;
    logic       pulse_out;
    logic       busy;
    logic       queue_full;
    logic       queue_empty;
    logic       overflow;
    logic [7:0] pulse_count;

    pulse_emitter #(.DELAY(D), .PULSE_WIDTH(PW), .DEPTH(DP)) dut (
        .clk(clk), .rst(rst), .trig_in(trig_in), .enable(enable),
        .pulse_out(pulse_out), .busy(busy), .queue_full(queue_full),
        .queue_empty(queue_empty), .overflow(overflow), .pulse_count(pulse_count)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: accepted trigger edges in a queue; each leaves at edge k+D+PW.
    int q[$];
    int e = 0;
    int last_acc = 0;
    bit have_last = 0;
    bit m_ovf = 0;
    int m_pcnt = 0;
    bit x_pulse = 0, x_busy = 0, x_full = 0, x_empty = 1;

    task automatic model_step();
        int pre, post;
        bit pop, cand, acc;
        if (!rst) begin
            q.delete();
            e = 0; have_last = 0; m_ovf = 0; m_pcnt = 0;
            x_pulse = 0; x_busy = 0; x_full = 0; x_empty = 1;
        end else begin
            e++;
            pre  = q.size();
            pop  = (pre > 0) && (q[0] + D + PW == e);
            cand = trig_in && enable && (!have_last || (e - last_acc >= PW + 1));
            if (cand && pre == DP && !pop) m_ovf = 1;
            acc  = cand && (pre < DP || pop);
            if (pop) begin
                void'(q.pop_front());
                m_pcnt = (m_pcnt + 1) % 256;
            end
            if (acc) begin
                q.push_back(e);
                last_acc = e;
                have_last = 1;
            end
            post = q.size();
            x_pulse = 0;
            foreach (q[i]) if (q[i] + D <= e && e < q[i] + D + PW) x_pulse = 1;
            x_busy  = (pre > 0) && (post > 0);
            x_full  = (post == DP);
            x_empty = (post == 0);
        end
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        chk("pulse_out",   32'(pulse_out),   32'(x_pulse));
        chk("busy",        32'(busy),        32'(x_busy));
        chk("queue_full",  32'(queue_full),  32'(x_full));
        chk("queue_empty", 32'(queue_empty), 32'(x_empty));
        chk("overflow",    32'(overflow),    32'(m_ovf));
        chk("pulse_count", 32'(pulse_count), 32'(m_pcnt));
    end

    int sched[$];
    bit rnd = 0;

    function automatic bit in_sched(input int x);
        foreach (sched[i]) if (sched[i] == x) return 1'b1;
        return 1'b0;
    endfunction

    // Advance until the state after edge `target` is visible; inputs for the next edge are driven each negedge.
    task automatic run_to(input int target);
        while (e < target) begin
            @(negedge clk);
            if (rnd) begin
                trig_in = ($urandom_range(0, 5) == 0);
                enable  = ($urandom_range(0, 15) != 0);
            end else begin
                trig_in = in_sched(e + 1);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        trig_in = 1'b0;
        sched.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; trig_in = 1'b0; enable = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_pulse", 32'(pulse_out), 0);
        chk("rst_empty", 32'(queue_empty), 1);
        chk("rst_count", 32'(pulse_count), 0);
        rst = 1'b1;

        // single trigger
        sched = '{10};
        run_to(10); chk("s1_busy10", 32'(busy), 0); chk("s1_nempty10", 32'(queue_empty), 0);
        run_to(11); chk("s1_busy11", 32'(busy), 1);
        run_to(59); chk("s1_p59", 32'(pulse_out), 0);
        run_to(60); chk("s1_p60", 32'(pulse_out), 1);
        run_to(63); chk("s1_p63", 32'(pulse_out), 1);
        run_to(64); chk("s1_p64", 32'(pulse_out), 0); chk("s1_cnt", 32'(pulse_count), 1);

        // dead time
        do_reset(); sched = '{10, 13};
        run_to(70); chk("s2_cnt", 32'(pulse_count), 1); chk("s2_ovf", 32'(overflow), 0);

        // overflow
        do_reset(); sched = '{10, 15, 20, 25, 30};
        run_to(25); chk("s3_full25", 32'(queue_full), 1);
        run_to(30); chk("s3_ovf", 32'(overflow), 1);
        run_to(63); chk("s3_full63", 32'(queue_full), 1);
        run_to(64); chk("s3_full64", 32'(queue_full), 0); chk("s3_p64", 32'(pulse_out), 0);
        run_to(65); chk("s3_p65", 32'(pulse_out), 1);
        run_to(75); chk("s3_p75", 32'(pulse_out), 1);
        run_to(80); chk("s3_cnt", 32'(pulse_count), 4); chk("s3_empty", 32'(queue_empty), 1);

        // reset mid-pulse
        do_reset(); sched = '{10};
        run_to(60);
        rst = 1'b0; trig_in = 1'b0; sched.delete();
        #1;
        chk("s4_p", 32'(pulse_out), 0); chk("s4_empty", 32'(queue_empty), 1); chk("s4_cnt", 32'(pulse_count), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_to(120); chk("s4_cnt_after", 32'(pulse_count), 0);

        // push on the pop edge while full
        do_reset(); sched = '{10, 15, 20, 25, 64};
        run_to(64); chk("s5_ovf", 32'(overflow), 0); chk("s5_full", 32'(queue_full), 1);
        run_to(113); chk("s5_p113", 32'(pulse_out), 0);
        run_to(114); chk("s5_p114", 32'(pulse_out), 1);
        run_to(117); chk("s5_p117", 32'(pulse_out), 1);
        run_to(118); chk("s5_p118", 32'(pulse_out), 0); chk("s5_cnt", 32'(pulse_count), 5);

        // enable gating
        do_reset(); sched = '{10, 20};
        run_to(10); enable = 1'b0;
        run_to(80); chk("s6_cnt", 32'(pulse_count), 1); chk("s6_empty", 32'(queue_empty), 1);
        enable = 1'b1;

        // timestamp wrap with repeated single triggers
        do_reset();
        for (int t = 10; t <= 570; t += 70) sched.push_back(t);
        run_to(620); chk("s7_p620", 32'(pulse_out), 1);
        run_to(640); chk("s7_cnt", 32'(pulse_count), 9);

        // random
        do_reset(); rnd = 1'b1;
        run_to(4500);
        rnd = 1'b0; trig_in = 1'b0; enable = 1'b1;
        do_reset(); rnd = 1'b1;
        run_to(1500);
        rnd = 1'b0; trig_in = 1'b0; enable = 1'b1;
        run_to(1600);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
